// File: rtl/dma_mem_if.sv
// Memory-master handshake between a DMA engine and its memory target.
// The requester holds req/we/addr/wdata stable until it sees ready.
interface dma_mem_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              ready;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/dma_mem_responder.sv
// SRAM-backed DMA memory target with fixed and LFSR-random wait states and address checking.
// Define DMA_MEM_RESP_STATS_EN to build the rd/wr/err completion counters.
module dma_mem_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                XLEN        = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  dma_mem_if.slave    dma_mem,
  input  logic        stall_en,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [4:0]        cnt_reg;
  logic [15:0]       lfsr_reg;
  logic [15:0]       lfsr_next;
  logic              ready_reg;
  logic              err_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic [4:0]        stall_req;
  logic              enter_resp;

  // Subtraction wraps for addresses below BASE_ADDR, so they land out of range.
  assign offset   = dma_mem.addr - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign addr_err = (dma_mem.addr[1:0] != 2'b00) || ((offset >> 2) >= ADDR_W'(DEPTH_WORDS));

  assign stall_req = 5'(WAIT_CYCLES) + (stall_en ? {3'b000, lfsr_reg[1:0]} : 5'd0);
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  assign enter_resp = dma_mem.req &&
                      (((state_reg == IDLE) && (stall_req == 5'd0)) ||
                       ((state_reg == WAIT) && (cnt_reg == 5'd1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      lfsr_reg  <= LFSR_SEED;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      lfsr_reg  <= lfsr_next;
      ready_reg <= 1'b0;
      // Response fields are captured on entry so they are stable for the whole RESP cycle.
      if (enter_resp) begin
        ready_reg <= 1'b1;
        err_reg   <= addr_err;
        rdata_reg <= addr_err ? '0 : mem[idx];
      end
      case (state_reg)
        IDLE: begin
          if (dma_mem.req) begin
            if (stall_req == 5'd0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= stall_req;
            end
          end
        end
        WAIT: begin
          if (!dma_mem.req) begin
            state_reg <= IDLE;
          end else if (cnt_reg == 5'd1) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 5'd1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Writes commit on the completion edge; kept reset-free so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (!rst && (state_reg == RESP) && dma_mem.we && !err_reg) begin
      mem[idx] <= dma_mem.wdata;
    end
  end

  assign dma_mem.ready = ready_reg;
  assign dma_mem.err   = err_reg;
  assign dma_mem.rdata = rdata_reg;

`ifdef DMA_MEM_RESP_STATS_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;
  logic [31:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_reg  <= '0;
      wr_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (state_reg == RESP) begin
      if (err_reg) begin
        err_count_reg <= err_count_reg + 32'd1;
      end else if (dma_mem.we) begin
        wr_count_reg <= wr_count_reg + 32'd1;
      end else begin
        rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  assign rd_count  = rd_count_reg;
  assign wr_count  = wr_count_reg;
  assign err_count = err_count_reg;
`else
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: three instances with WAIT_CYCLES of 0, 3 and 5.
// Counter expectations follow whether DMA_MEM_RESP_STATS_EN is defined.
module tb_dma_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_v [3];
  logic        we_v [3];
  logic        se_v [3];
  logic [31:0] addr_v [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        err_v [3];
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
  logic [31:0] erc [3];
  logic        bad_ready = 1'b0;

  dma_mem_if m_if [3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 3 : 5);
      assign m_if[gi].req   = req_v[gi];
      assign m_if[gi].we    = we_v[gi];
      assign m_if[gi].addr  = addr_v[gi];
      assign m_if[gi].wdata = wdata_v[gi];
      assign rdata_v[gi]    = m_if[gi].rdata;
      assign ready_v[gi]    = m_if[gi].ready;
      assign err_v[gi]      = m_if[gi].err;

      dma_mem_responder #(.WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .dma_mem   (m_if[gi]),
        .stall_en  (se_v[gi]),
        .rd_count  (rdc[gi]),
        .wr_count  (wrc[gi]),
        .err_count (erc[gi])
      );
    end
  endgenerate

  // Sticky flag: ready must never be seen while the requester is idle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ready_v[i] === 1'b1 && req_v[i] !== 1'b1) bad_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is #1 after a posedge. lat = edges until ready is seen (1 + stall).
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    logic to = 1'b1;
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ready_v[d] === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    rd = rdata_v[d];
    e  = err_v[d];
    chk("timeout", 32'(to), 32'd0);
    @(posedge clk); #1;
    req_v[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          c0;
    logic [31:0] expd [200];

    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; se_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_v[0]), 32'd0);
    chk("rst_err", 32'(err_v[0]), 32'd0);
    chk("rst_rdata", rdata_v[0], 32'd0);
    chk("rst_err_count", erc[0], 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: write then read back
    access(0, 1'b1, 32'h100, 32'hA5A50000, rd, e, lat);
    chk("wr_lat0", 32'(lat), 32'd1);
    chk("wr_err0", 32'(e), 32'd0);
    access(0, 1'b0, 32'h100, 32'h0, rd, e, lat);
    chk("rd_lat0", 32'(lat), 32'd1);
    chk("rd_data0", rd, 32'hA5A50000);
    chk("rd_err0", 32'(e), 32'd0);

    // Error cases: misaligned, out of range, and an out-of-range write aliasing word 0
    access(0, 1'b1, 32'h0, 32'h0BADC0DE, rd, e, lat);
    access(0, 1'b0, 32'h102, 32'h0, rd, e, lat);
    chk("misalign_err", 32'(e), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    access(0, 1'b0, 32'h1000, 32'h0, rd, e, lat);
    chk("oor_rd_err", 32'(e), 32'd1);
    chk("oor_rd_rdata", rd, 32'd0);
    access(0, 1'b1, 32'h1000, 32'hFFFFFFFF, rd, e, lat);
    chk("oor_wr_err", 32'(e), 32'd1);
    access(0, 1'b0, 32'h0, 32'h0, rd, e, lat);
    chk("word0_intact", rd, 32'h0BADC0DE);
    chk("word0_err", 32'(e), 32'd0);
`ifdef DMA_MEM_RESP_STATS_EN
    chk("rd_count", rdc[0], 32'd2);
    chk("wr_count", wrc[0], 32'd2);
    chk("err_count", erc[0], 32'd3);
`else
    chk("rd_count", rdc[0], 32'd0);
    chk("wr_count", wrc[0], 32'd0);
    chk("err_count", erc[0], 32'd0);
`endif

    // Three fixed wait states
    access(1, 1'b1, 32'h40, 32'h13579BDF, rd, e, lat);
    chk("w3_wr_lat", 32'(lat), 32'd4);
    access(1, 1'b0, 32'h40, 32'h0, rd, e, lat);
    chk("w3_rd_lat", 32'(lat), 32'd4);
    chk("w3_rd_data", rd, 32'h13579BDF);
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      access(1, 1'b0, 32'h40, 32'h0, rd, e, lat);
      chk("b2b_data", rd, 32'h13579BDF);
    end
    chk("b2b_cycles", 32'(cyc - c0), 32'd80);

    // Random stalls
    se_v[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      expd[i] = $urandom;
      access(0, 1'b1, 32'((i * 5) % 1024) << 2, expd[i], rd, e, lat);
      chk("rnd_wr_lat_range", 32'(lat + 1 >= 2 && lat + 1 <= 5), 32'd1);
    end
    for (int i = 0; i < 200; i++) begin
      access(0, 1'b0, 32'((i * 5) % 1024) << 2, 32'h0, rd, e, lat);
      chk("rnd_rd_data", rd, expd[i]);
      chk("rnd_rd_lat_range", 32'(lat + 1 >= 2 && lat + 1 <= 5), 32'd1);
    end
    se_v[0] = 1'b0;
    chk("ready_without_req", 32'(bad_ready), 32'd0);

    // Reset during WAIT of a write
    access(2, 1'b1, 32'h200, 32'hDEADBEEF, rd, e, lat);
    chk("w5_wr_lat", 32'(lat), 32'd6);
    req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h200; wdata_v[2] = 32'h11111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_ready", 32'(ready_v[2]), 32'd0);
    chk("rst_wait_rdata", rdata_v[2], 32'd0);
    rst = 1'b0;
    req_v[2] = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(ready_v[2]), 32'd0);
    access(2, 1'b0, 32'h200, 32'h0, rd, e, lat);
    chk("rst_no_write", rd, 32'hDEADBEEF);
    chk("post_rst_lat", 32'(lat), 32'd6);

    // Abort: drop req in WAIT
    access(2, 1'b1, 32'h300, 32'hCAFEF00D, rd, e, lat);
    req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h300; wdata_v[2] = 32'h55555555;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_ready_pre", 32'(ready_v[2]), 32'd0);
    end
    req_v[2] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_ready_post", 32'(ready_v[2]), 32'd0);
    end
    access(2, 1'b0, 32'h300, 32'h0, rd, e, lat);
    chk("abort_no_write", rd, 32'hCAFEF00D);
    chk("abort_next_lat", 32'(lat), 32'd6);
    chk("ready_without_req_end", 32'(bad_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
